exec_pipe: RTL and testbench
============================

EXEC_PIPE -- requirements
Module: exec_pipe

Interface
Parameters:
REQ-001 NREG, 32, number of integer registers: 32 for RV32I, 16 for RV32E.
REQ-002 XLEN, 32, datapath width; 32 is the only legal value, and elaboration SHALL fail on any other value.
Ports (name  direction  width  meaning):
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 pc_i  in  32  PC of inst_i.
REQ-006 inst_v_i  in  1  inst_i valid.
REQ-007 inst_i  in  32  instruction from fetch.
REQ-008 inst_rdy_o  out  1  stage can accept an instruction; fetch holds pc_i/inst_i while low.
REQ-009 pc_v_x  out  1  redirect request, single-cycle.
REQ-010 pc_x  out  32  redirect target.
REQ-011 illegal_x  out  1  pulse: unsupported encoding, or register index >= NREG.
REQ-012 dmem_req  out  1  data request valid.
REQ-013 dmem_we  out  1  1 = store, 0 = load.
REQ-014 dmem_addr  out  32  word-aligned byte address (rs1+imm with [1:0] cleared).
REQ-015 dmem_be  out  4  byte enables.
REQ-016 dmem_wdata  out  32  store data, lane-aligned.
REQ-017 dmem_gnt  in  1  request accepted when dmem_req&dmem_gnt.
REQ-018 dmem_rvalid  in  1  load data valid, at least one cycle after grant.
REQ-019 dmem_rdata  in  32  load data.

Function
REQ-020 Handshake: capture inst_i/pc_i when inst_v_i&inst_rdy_o; the captured instruction executes in X the next cycle.
REQ-021 Register file: NREG x 32, synchronous read addressed by inst_i[19:15]/[24:20] at capture; x0 reads 0 and is never written.
REQ-022 Bypass: a writeback on the same edge as the read of the same nonzero rd forwards the written data to X.
REQ-023 Operations: all RV32I OP and OP-IMM (ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND and the immediate forms), LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW; FENCE executes as a NOP.
REQ-024 ALU/branch instructions complete in X in one cycle; rd is written at the end of X.
REQ-025 JAL/JALR: rd=pc+4; pc_v_x=1; pc_x=pc+imm, or (rs1+imm)&~1 for JALR.
REQ-026 Taken branch: pc_v_x=1, pc_x=pc+b_imm; not taken: pc_v_x=0.
REQ-027 The stage does not kill the instruction following a redirect; fetch flushes it and drops inst_v_i.
REQ-028 FSM states: EXEC, REQ, WAIT.
  EXEC -> REQ: load or store in X.
  REQ -> WAIT: load granted.
  REQ -> EXEC: store granted.
  WAIT -> EXEC: dmem_rvalid.
REQ-029 dmem_req=1 only in REQ; address, we, be and wdata SHALL be held stable until granted.
REQ-030 inst_rdy_o=0 in REQ/WAIT, except: high in the grant cycle of a store and in the dmem_rvalid cycle of a load, so capture coincides with completion.
REQ-031 Load result: the addressed byte/half, sign- or zero-extended per funct3, written to rd in the dmem_rvalid cycle; a later dmem_rvalid in EXEC is ignored.
REQ-032 Misaligned access (LH/SH with addr[0]=1, LW/SW with addr[1:0]!=0): illegal_x=1, no request issued, no write.
REQ-033 Illegal instruction: illegal_x=1 for one cycle; no register write, no redirect, no request.
REQ-034 Shift amount SHALL be rs2[4:0] or imm[4:0]; arithmetic wraps modulo 2^32.

Reset
REQ-035 Reset SHALL clear instruction valid, set FSM=EXEC, and drive pc_v_x=0, illegal_x=0, dmem_req=0, inst_rdy_o=1 in the next cycle.
REQ-036 Register contents are not reset.
REQ-037 Reset in REQ/WAIT abandons the access; a pending dmem_rvalid after reset is ignored.

Verification
REQ-038 addi x1,x0,5 then add x2,x1,x1 back-to-back -> x2=10 via bypass.
REQ-039 x3=0x80000000; srai x4,x3,4 -> 0xF8000000; srli -> 0x08000000.
REQ-040 pc=0x100, blt x5,x6,+16 with x5=-1, x6=1 -> pc_v_x=1, pc_x=0x110; bltu same operands -> pc_v_x=0.
REQ-041 x7=0x200; sw x8=0x11223344 at 0(x7), gnt delayed 3 cycles -> req held 4 cycles, be=0xF; lb x9,3(x7) with rvalid 2 cycles later, rdata=0x11223344 -> x9=0x00000011, inst_rdy_o low until rvalid.
REQ-042 NREG=16: addi x20,x0,1 -> illegal_x=1, no write; lw at 0x202 -> illegal_x=1, dmem_req=0.
REQ-043 Reset asserted while in WAIT -> next cycle FSM=EXEC, dmem_req=0; a late rvalid does not write rd.

Source files
------------

// File: rtl/exec_pipe.sv
// exec_pipe: RV32I/E execute stage with register file, branch redirect and single-port data memory access
module exec_pipe #(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_i,
  input  logic        inst_v_i,
  input  logic [31:0] inst_i,
  output logic        inst_rdy_o,
  output logic        pc_v_x,
  output logic [31:0] pc_x,
  output logic        illegal_x,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);
  if (XLEN != 32) begin : g_xlen
    $error("exec_pipe: XLEN must be 32");
  end
  typedef enum logic [1:0] {EXEC, REQ, WAIT} state_t;
  state_t state, state_d;
  logic        x_v;
  logic [31:0] x_inst, x_pc, rs1_q, rs2_q;
  logic [31:0] rf [32];
  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, ra1, ra2;
  assign op  = x_inst[6:0];
  assign rd  = x_inst[11:7];
  assign f3  = x_inst[14:12];
  assign ra1 = x_inst[19:15];
  assign ra2 = x_inst[24:20];
  assign f7  = x_inst[31:25];
  logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op, is_fence;
  assign is_lui   = op == 7'h37;
  assign is_auipc = op == 7'h17;
  assign is_jal   = op == 7'h6f;
  assign is_jalr  = op == 7'h67;
  assign is_br    = op == 7'h63;
  assign is_ld    = op == 7'h03;
  assign is_st    = op == 7'h23;
  assign is_opi   = op == 7'h13;
  assign is_op    = op == 7'h33;
  assign is_fence = op == 7'h0f;
  logic sh_ok, op_ok, enc_ok, use_rd, use_rs1, use_rs2, legal;
  assign sh_ok = f3 == 3'b001 ? f7 == 7'h00 : f3 == 3'b101 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
  assign op_ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
  assign enc_ok = is_lui || is_auipc || is_jal || (is_jalr && f3 == 3'b000) ||
                  (is_br && f3[2:1] != 2'b01) || (is_ld && f3 != 3'b011 && f3[2:1] != 2'b11) ||
                  (is_st && !f3[2] && f3[1:0] != 2'b11) || (is_opi && sh_ok) ||
                  (is_op && op_ok) || (is_fence && f3 == 3'b000);
  assign use_rd  = is_lui || is_auipc || is_jal || is_jalr || is_opi || is_op || is_ld;
  assign use_rs1 = is_jalr || is_br || is_ld || is_st || is_opi || is_op;
  assign use_rs2 = is_br || is_st || is_op;
  assign legal = enc_ok && !(use_rd && int'(rd) >= NREG) && !(use_rs1 && int'(ra1) >= NREG) &&
                 !(use_rs2 && int'(ra2) >= NREG);
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  assign i_imm = {{20{x_inst[31]}}, x_inst[31:20]};
  assign s_imm = {{20{x_inst[31]}}, x_inst[31:25], x_inst[11:7]};
  assign b_imm = {{20{x_inst[31]}}, x_inst[7], x_inst[30:25], x_inst[11:8], 1'b0};
  assign u_imm = {x_inst[31:12], 12'b0};
  assign j_imm = {{12{x_inst[31]}}, x_inst[19:12], x_inst[20], x_inst[30:21], 1'b0};
  logic [31:0] opb, alu, ex_res;
  logic [4:0]  sh;
  assign opb = is_op ? rs2_q : i_imm;
  assign sh  = opb[4:0];
  always_comb begin
    alu = rs1_q + opb;
    case (f3)
      3'b000: alu = (is_op && f7[5]) ? rs1_q - opb : rs1_q + opb;
      3'b001: alu = rs1_q << sh;
      3'b010: alu = {31'b0, $signed(rs1_q) < $signed(opb)};
      3'b011: alu = {31'b0, rs1_q < opb};
      3'b100: alu = rs1_q ^ opb;
      3'b101: alu = f7[5] ? 32'($signed(rs1_q) >>> sh) : rs1_q >> sh;
      3'b110: alu = rs1_q | opb;
      default: alu = rs1_q & opb;
    endcase
  end
  assign ex_res = is_lui ? u_imm : is_auipc ? x_pc + u_imm : (is_jal || is_jalr) ? x_pc + 32'd4 : alu;
  logic taken;
  assign taken = f3[2:1] == 2'b00 ? (rs1_q == rs2_q) ^ f3[0] :
                 f3[2:1] == 2'b10 ? ($signed(rs1_q) < $signed(rs2_q)) ^ f3[0] :
                 (rs1_q < rs2_q) ^ f3[0];
  logic [31:0] ea, lsh, ld_val;
  logic        misal, mem_op, ex, go_mem, ld_done, wb_en;
  logic [31:0] wb_data;
  assign ea     = rs1_q + (is_st ? s_imm : i_imm);
  assign misal  = f3[1:0] == 2'b01 ? ea[0] : f3[1:0] == 2'b10 ? ea[1:0] != 2'b00 : 1'b0;
  assign mem_op = (is_ld || is_st) && legal;
  assign ex     = state == EXEC && x_v;
  assign go_mem = ex && mem_op && !misal;
  assign illegal_x = ex && (!legal || (mem_op && misal));
  assign pc_v_x    = ex && legal && (is_jal || is_jalr || (is_br && taken));
  assign pc_x      = is_jalr ? (rs1_q + i_imm) & ~32'h1 : x_pc + (is_jal ? j_imm : b_imm);
  assign dmem_req   = state == REQ;
  assign dmem_we    = is_st;
  assign dmem_addr  = {ea[31:2], 2'b00};
  assign dmem_be    = f3[1:0] == 2'b00 ? 4'b0001 << ea[1:0] : f3[1:0] == 2'b01 ? (ea[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign dmem_wdata = f3[1:0] == 2'b00 ? {4{rs2_q[7:0]}} : f3[1:0] == 2'b01 ? {2{rs2_q[15:0]}} : rs2_q;
  assign lsh    = dmem_rdata >> {ea[1:0], 3'b000};
  assign ld_val = f3[1:0] == 2'b00 ? {{24{~f3[2] & lsh[7]}}, lsh[7:0]} :
                  f3[1:0] == 2'b01 ? {{16{~f3[2] & lsh[15]}}, lsh[15:0]} : lsh;
  assign ld_done = state == WAIT && dmem_rvalid;
  assign wb_en   = !reset && rd != 5'd0 && ((ex && legal && use_rd && !is_ld) || ld_done);
  assign wb_data = ld_done ? ld_val : ex_res;
  // The next instruction is accepted only in the cycle the current one finishes
  assign inst_rdy_o = state == EXEC ? !go_mem : state == REQ ? dmem_gnt && is_st : dmem_rvalid;
  always_comb begin
    state_d = state;
    case (state)
      EXEC: state_d = go_mem ? REQ : EXEC;
      REQ: state_d = dmem_gnt ? (is_st ? EXEC : WAIT) : REQ;
      WAIT: state_d = dmem_rvalid ? EXEC : WAIT;
      default: state_d = EXEC;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EXEC;
      x_v <= 1'b0;
    end else begin
      state <= state_d;
      if (inst_rdy_o) x_v <= inst_v_i;
    end
  end
  logic [4:0]  ca1, ca2;
  logic [31:0] rv1, rv2;
  assign ca1 = inst_i[19:15];
  assign ca2 = inst_i[24:20];
  assign rv1 = ca1 == 5'd0 ? 32'd0 : (wb_en && rd == ca1) ? wb_data : rf[ca1];
  assign rv2 = ca2 == 5'd0 ? 32'd0 : (wb_en && rd == ca2) ? wb_data : rf[ca2];
  always_ff @(posedge clk) begin
    if (inst_v_i && inst_rdy_o) begin
      x_inst <= inst_i;
      x_pc <= pc_i;
      rs1_q <= rv1;
      rs2_q <= rv2;
    end
    if (wb_en) rf[rd] <= wb_data;
  end
endmodule

// File: tb/tb_exec_pipe.sv
// tb_exec_pipe: directed vector table plus memory handshake sequences for exec_pipe (RV32I and RV32E instances)
module tb_exec_pipe;
  logic clk = 1'b0, reset = 1'b1;
  logic [31:0] pc_i = '0, inst_i = '0, dmem_rdata = '0;
  logic inst_v_i = 1'b0, dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic inst_rdy_o, pc_v_x, illegal_x, dmem_req, dmem_we;
  logic [31:0] pc_x, dmem_addr, dmem_wdata;
  logic [3:0] dmem_be;
  logic e_rdy, e_pcv, e_ill, e_req, e_we;
  logic [31:0] e_pcx, e_addr, e_wdata;
  logic [3:0] e_be;
  int total = 0, bad = 0;
  localparam logic [6:0] OP = 7'h33, OPI = 7'h13, LUI = 7'h37, AUIPC = 7'h17, JALR = 7'h67, LD = 7'h03, FENCE = 7'h0f;

  always #5 clk = ~clk;

  exec_pipe dut (
    .clk(clk), .reset(reset), .pc_i(pc_i), .inst_v_i(inst_v_i), .inst_i(inst_i), .inst_rdy_o(inst_rdy_o),
    .pc_v_x(pc_v_x), .pc_x(pc_x), .illegal_x(illegal_x), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  exec_pipe #(.NREG(16)) dut_e (
    .clk(clk), .reset(reset), .pc_i(pc_i), .inst_v_i(inst_v_i), .inst_i(inst_i), .inst_rdy_o(e_rdy),
    .pc_v_x(e_pcv), .pc_x(e_pcx), .illegal_x(e_ill), .dmem_req(e_req), .dmem_we(e_we),
    .dmem_addr(e_addr), .dmem_be(e_be), .dmem_wdata(e_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );

  typedef struct {
    logic [31:0] inst, pc;
    logic pcv;
    logic [31:0] pcx;
    logic ill, chkr;
    logic [31:0] val;
  } vec_t;
  vec_t tv[$];

  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2, rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [4:0] rs2, rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] u_t(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] j_t(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction
  function automatic void add(input logic [31:0] inst, pc, input logic pcv, input logic [31:0] pcx, input logic ill, chkr, input logic [31:0] val);
    vec_t v;
    v.inst = inst; v.pc = pc; v.pcv = pcv; v.pcx = pcx; v.ill = ill; v.chkr = chkr; v.val = val;
    tv.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask
  task automatic chb(input string nm, input logic act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%b exp=%b", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] ins, pc);
    int n;
    n = 0;
    @(negedge clk);
    while (!inst_rdy_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) begin
      total++;
      bad++;
      $display("FAIL issue_timeout act=rdy_low exp=rdy_high");
    end
    inst_v_i = 1'b1; inst_i = ins; pc_i = pc;
    @(posedge clk); #1;
    inst_v_i = 1'b0;
  endtask

  task automatic mem_store(input string nm, input logic [31:0] ins, ad, input logic [3:0] be, input logic [31:0] wd, input int gd);
    issue(ins, 32'h0);
    chb({nm, "_x_req"}, dmem_req, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i <= gd; i++) begin
      chb({nm, "_req"}, dmem_req, 1'b1);
      chb({nm, "_we"}, dmem_we, 1'b1);
      chb({nm, "_rdy"}, inst_rdy_o, 1'b0);
      chk({nm, "_addr"}, dmem_addr, ad);
      chk({nm, "_be"}, {28'h0, dmem_be}, {28'h0, be});
      chk({nm, "_wdata"}, dmem_wdata, wd);
      if (i < gd) begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk); dmem_gnt = 1'b1; #1;
    chb({nm, "_gnt_rdy"}, inst_rdy_o, 1'b1);
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    chb({nm, "_done_req"}, dmem_req, 1'b0);
  endtask

  task automatic peek(input logic [4:0] r, input logic [31:0] exp);
    mem_store($sformatf("x%0d", r), s_t(12'h0, r, 5'd0, 3'b010), 32'h0, 4'hF, exp, 0);
  endtask

  task automatic mem_load(input string nm, input logic [31:0] ins, ad, input logic [3:0] be, input logic [31:0] data, input int rv);
    issue(ins, 32'h0);
    @(posedge clk); #1;
    chb({nm, "_req"}, dmem_req, 1'b1);
    chb({nm, "_we"}, dmem_we, 1'b0);
    chk({nm, "_addr"}, dmem_addr, ad);
    chk({nm, "_be"}, {28'h0, dmem_be}, {28'h0, be});
    @(negedge clk); dmem_gnt = 1'b1; #1;
    chb({nm, "_gnt_rdy"}, inst_rdy_o, 1'b0);
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    for (int i = 1; i < rv; i++) begin
      chb({nm, "_wait_rdy"}, inst_rdy_o, 1'b0);
      chb({nm, "_wait_req"}, dmem_req, 1'b0);
      @(posedge clk); #1;
    end
    @(negedge clk); dmem_rvalid = 1'b1; dmem_rdata = data; #1;
    chb({nm, "_rv_rdy"}, inst_rdy_o, 1'b1);
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    add(u_t(20'h80000, 3, LUI), 0, 0, 0, 0, 1, 32'h80000000);
    add(i_t(12'h404, 3, 5, 4, OPI), 0, 0, 0, 0, 1, 32'hF8000000);
    add(i_t(12'h004, 3, 5, 4, OPI), 0, 0, 0, 0, 1, 32'h08000000);
    add(i_t(12'hFFF, 0, 0, 5, OPI), 0, 0, 0, 0, 1, 32'hFFFFFFFF);
    add(i_t(12'h001, 0, 0, 6, OPI), 0, 0, 0, 0, 1, 32'h1);
    add(b_t(13'h10, 6, 5, 3'b100), 32'h100, 1, 32'h110, 0, 0, 0);
    add(b_t(13'h10, 6, 5, 3'b110), 32'h100, 0, 0, 0, 0, 0);
    add(b_t(13'h8, 5, 6, 3'b101), 32'h40, 1, 32'h48, 0, 0, 0);
    add(b_t(13'h1FFC, 6, 6, 3'b000), 32'h40, 1, 32'h3C, 0, 0, 0);
    add(b_t(13'h1FFC, 6, 6, 3'b001), 32'h40, 0, 0, 0, 0, 0);
    add(b_t(13'hC, 6, 5, 3'b111), 0, 1, 32'hC, 0, 0, 0);
    add(r_t(7'h00, 6, 5, 0, 7, OP), 0, 0, 0, 0, 1, 32'h0);
    add(r_t(7'h20, 5, 6, 0, 7, OP), 0, 0, 0, 0, 1, 32'h2);
    add(r_t(7'h00, 6, 5, 1, 7, OP), 0, 0, 0, 0, 1, 32'hFFFFFFFE);
    add(r_t(7'h00, 6, 5, 2, 7, OP), 0, 0, 0, 0, 1, 32'h1);
    add(r_t(7'h00, 6, 5, 3, 7, OP), 0, 0, 0, 0, 1, 32'h0);
    add(r_t(7'h20, 6, 3, 5, 7, OP), 0, 0, 0, 0, 1, 32'hC0000000);
    add(r_t(7'h00, 6, 3, 5, 7, OP), 0, 0, 0, 0, 1, 32'h40000000);
    add(i_t(12'h0F0, 5, 4, 7, OPI), 0, 0, 0, 0, 1, 32'hFFFFFF0F);
    add(i_t(12'h7F0, 6, 6, 7, OPI), 0, 0, 0, 0, 1, 32'h000007F1);
    add(i_t(12'hFF0, 5, 7, 7, OPI), 0, 0, 0, 0, 1, 32'hFFFFFFF0);
    add(i_t(12'h000, 5, 2, 7, OPI), 0, 0, 0, 0, 1, 32'h1);
    add(i_t(12'hFFF, 6, 3, 7, OPI), 0, 0, 0, 0, 1, 32'h1);
    add(u_t(20'h12345, 7, AUIPC), 32'h200, 0, 0, 0, 1, 32'h12345200);
    add(r_t(7'h01, 6, 5, 0, 7, OP), 0, 0, 0, 1, 1, 32'h12345200);
    add(i_t(12'h404, 5, 1, 7, OPI), 0, 0, 0, 1, 1, 32'h12345200);
    add(i_t(12'h0FF, 0, 0, 0, FENCE), 0, 0, 0, 0, 0, 0);
    add(r_t(7'h00, 6, 6, 0, 0, OP), 0, 0, 0, 0, 1, 32'h0);
    add(j_t(21'h20, 8), 32'h300, 1, 32'h320, 0, 1, 32'h304);
    add(i_t(12'h007, 6, 0, 9, JALR), 32'h400, 1, 32'h8, 0, 1, 32'h404);
    add(32'h0000007F, 0, 0, 0, 1, 0, 0);
    add(i_t(12'h055, 0, 0, 10, OPI), 0, 0, 0, 0, 1, 32'h55);

    repeat (2) @(posedge clk);
    #1;
    chb("rst_rdy", inst_rdy_o, 1'b1);
    chb("rst_pcv", pc_v_x, 1'b0);
    chb("rst_ill", illegal_x, 1'b0);
    chb("rst_req", dmem_req, 1'b0);
    chb("rst_e_rdy", e_rdy, 1'b1);
    @(negedge clk); reset = 1'b0;

    issue(i_t(12'h005, 0, 0, 1, OPI), 0);
    issue(r_t(7'h00, 1, 1, 0, 2, OP), 0);
    peek(2, 32'd10);

    foreach (tv[k]) begin
      issue(tv[k].inst, tv[k].pc);
      chb($sformatf("v%0d_pcv", k), pc_v_x, tv[k].pcv);
      if (tv[k].pcv) chk($sformatf("v%0d_pcx", k), pc_x, tv[k].pcx);
      chb($sformatf("v%0d_ill", k), illegal_x, tv[k].ill);
      if (tv[k].chkr) peek(tv[k].inst[11:7], tv[k].val);
    end

    issue(i_t(12'h200, 0, 0, 7, OPI), 0);
    issue(u_t(20'h11223, 8, LUI), 0);
    issue(i_t(12'h344, 8, 0, 8, OPI), 0);
    mem_store("sw", s_t(12'h0, 8, 7, 3'b010), 32'h200, 4'hF, 32'h11223344, 3);
    mem_load("lb", i_t(12'h003, 7, 0, 9, LD), 32'h200, 4'b1000, 32'h11223344, 2);
    peek(9, 32'h00000011);
    mem_load("lh", i_t(12'h002, 7, 1, 11, LD), 32'h200, 4'b1100, 32'h80010000, 1);
    peek(11, 32'hFFFF8001);
    mem_load("lhu", i_t(12'h002, 7, 5, 11, LD), 32'h200, 4'b1100, 32'h80010000, 1);
    peek(11, 32'h00008001);
    mem_load("lbu", i_t(12'h001, 7, 4, 11, LD), 32'h200, 4'b0010, 32'h0000F000, 3);
    peek(11, 32'h000000F0);
    mem_store("sb", s_t(12'h001, 6, 7, 3'b000), 32'h200, 4'b0010, 32'h01010101, 0);
    mem_store("sh", s_t(12'h002, 5, 7, 3'b001), 32'h200, 4'b1100, 32'hFFFFFFFF, 1);

    issue(i_t(12'h002, 7, 2, 7, LD), 0);
    chb("mis_lw_ill", illegal_x, 1'b1);
    chb("mis_lw_req", dmem_req, 1'b0);
    chb("mis_lw_rdy", inst_rdy_o, 1'b1);
    chb("e_mis_lw_ill", e_ill, 1'b1);
    @(posedge clk); #1;
    chb("mis_lw_req2", dmem_req, 1'b0);
    chb("e_mis_lw_req2", e_req, 1'b0);
    peek(7, 32'h200);
    issue(s_t(12'h001, 5, 7, 3'b001), 0);
    chb("mis_sh_ill", illegal_x, 1'b1);
    @(posedge clk); #1;
    chb("mis_sh_req", dmem_req, 1'b0);

    issue(i_t(12'h001, 0, 0, 20, OPI), 0);
    chb("e_x20_ill", e_ill, 1'b1);
    chb("x20_ill", illegal_x, 1'b0);
    peek(20, 32'h1);

    issue(i_t(12'h000, 7, 2, 10, LD), 0);
    @(posedge clk); #1;
    chb("rw_req", dmem_req, 1'b1);
    @(negedge clk); dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    chb("rw_wait_rdy", inst_rdy_o, 1'b0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    chb("rw_rst_req", dmem_req, 1'b0);
    chb("rw_rst_rdy", inst_rdy_o, 1'b1);
    chb("rw_rst_ill", illegal_x, 1'b0);
    chb("rw_rst_pcv", pc_v_x, 1'b0);
    chb("e_rw_rst_req", e_req, 1'b0);
    @(negedge clk); reset = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    chb("rw_late_req", dmem_req, 1'b0);
    peek(10, 32'h55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
